// File: rtl/forth_dbus.sv
// Data-bus decoder for a small Forth core: 240-word RAM, a TX-only 8N1 UART
// behind a byte FIFO, an LED register and a free-running cycle counter.
module forth_dbus #(
  parameter int width       = 16,
  parameter int daddr_width = 8,    // must be >= 8
  parameter int baud_div    = 434,  // clocks per UART bit, >= 2
  parameter int fifo_depth  = 4     // power of 2, >= 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [daddr_width-1:0] daddr,
  input  logic [width-1:0]       ddata_write,
  input  logic                   dwrite,
  output logic [width-1:0]       ddata_read,
  output logic                   uart_tx,
  output logic [7:0]             led
);

  localparam int RAM_WORDS = 240;
  localparam int FAW = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
  localparam int BW  = (baud_div > 1) ? $clog2(baud_div) : 1;

  localparam logic [daddr_width-1:0] A_UDATA = daddr_width'(32'hF0);
  localparam logic [daddr_width-1:0] A_USTAT = daddr_width'(32'hF1);
  localparam logic [daddr_width-1:0] A_LED   = daddr_width'(32'hF2);
  localparam logic [daddr_width-1:0] A_CNT   = daddr_width'(32'hF3);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  logic is_ram, is_udata, is_ustat, is_led, is_cnt, wr;
  logic [7:0] ram_idx;

  always_comb begin
    is_ram   = (daddr < A_UDATA);
    is_udata = (daddr == A_UDATA);
    is_ustat = (daddr == A_USTAT);
    is_led   = (daddr == A_LED);
    is_cnt   = (daddr == A_CNT);
    wr       = dwrite & ~reset;
    ram_idx  = daddr[7:0];
  end

  // RAM: read-before-write, so a same-cycle read sees the old word
  logic [width-1:0] ram [0:RAM_WORDS-1];
  logic [width-1:0] ram_rd_q;

  always_ff @(posedge clk) begin
    if (is_ram) begin
      ram_rd_q <= ram[ram_idx];
    end
    if (wr && is_ram) begin
      ram[ram_idx] <= ddata_write;
    end
  end

  logic [width-1:0] cnt_q, cnt_d;
  logic [7:0]       led_q, led_d;
  logic             ovf_q, ovf_d;
  logic             rd_sel_ram_q, rd_sel_ram_d;
  logic [width-1:0] rd_periph_q, rd_periph_d;

  logic [7:0]   fifo_mem [0:fifo_depth-1];
  logic [FAW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [FAW:0]   count_q, count_d;
  logic fifo_full, fifo_empty, push_req, push, pop;
  logic [7:0] fifo_head;

  logic [1:0]    state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          tx_q, tx_d;
  logic          baud_last, tx_busy;

  always_comb begin
    fifo_full  = (count_q == (FAW+1)'(fifo_depth));
    fifo_empty = (count_q == '0);
    fifo_head  = fifo_mem[rp_q];
    push_req   = wr && is_udata;
    // fullness is judged before the edge; a concurrent pop does not make room
    push       = push_req && !fifo_full;
    baud_last  = (baud_q == BW'(baud_div - 1));
    tx_busy    = !fifo_empty || (state_q != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wp_q] <= ddata_write[7:0];
    end
  end

  // Transmitter: pops in IDLE, or at the end of STOP for back-to-back frames
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          sh_d    = fifo_head;
          state_d = ST_START;
          baud_d  = '0;
          tx_d    = 1'b0;
        end
      end
      ST_START: begin
        if (baud_last) begin
          state_d = ST_DATA;
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = sh_q[0];
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      ST_DATA: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
            sh_d  = {1'b0, sh_q[7:1]};
            tx_d  = sh_q[1];
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      ST_STOP: begin
        if (baud_last) begin
          baud_d = '0;
          if (!fifo_empty) begin
            pop     = 1'b1;
            sh_d    = fifo_head;
            state_d = ST_START;
            tx_d    = 1'b0;
          end else begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_comb begin
    wp_d    = push ? wp_q + FAW'(1) : wp_q;
    rp_d    = pop ? rp_q + FAW'(1) : rp_q;
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (FAW+1)'(1);
      2'b01:   count_d = count_q - (FAW+1)'(1);
      default: count_d = count_q;
    endcase

    ovf_d = ovf_q;
    if (wr && is_ustat) ovf_d = 1'b0;
    if (push_req && fifo_full) ovf_d = 1'b1;

    led_d = (wr && is_led) ? ddata_write[7:0] : led_q;
    cnt_d = (wr && is_cnt) ? ddata_write : cnt_q + width'(1);

    rd_sel_ram_d = is_ram;
    rd_periph_d  = '0;
    if (is_ustat) rd_periph_d[2:0] = {ovf_q, fifo_full, tx_busy};
    if (is_led)   rd_periph_d[7:0] = led_q;
    if (is_cnt)   rd_periph_d      = cnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q        <= '0;
      led_q        <= '0;
      ovf_q        <= 1'b0;
      rd_sel_ram_q <= 1'b0;
      rd_periph_q  <= '0;
      wp_q         <= '0;
      rp_q         <= '0;
      count_q      <= '0;
      state_q      <= ST_IDLE;
      baud_q       <= '0;
      bit_q        <= '0;
      sh_q         <= '0;
      tx_q         <= 1'b1;
    end else begin
      cnt_q        <= cnt_d;
      led_q        <= led_d;
      ovf_q        <= ovf_d;
      rd_sel_ram_q <= rd_sel_ram_d;
      rd_periph_q  <= rd_periph_d;
      wp_q         <= wp_d;
      rp_q         <= rp_d;
      count_q      <= count_d;
      state_q      <= state_d;
      baud_q       <= baud_d;
      bit_q        <= bit_d;
      sh_q         <= sh_d;
      tx_q         <= tx_d;
    end
  end

  assign ddata_read = rd_sel_ram_q ? ram_rd_q : rd_periph_q;
  assign uart_tx    = tx_q;
  assign led        = led_q;

endmodule

// File: tb/tb_forth_dbus.sv
// Bench for forth_dbus: directed vector table, hand-built UART/reset sequences
// and random bus traffic checked against a cycle-level behavioural model.
module tb_forth_dbus;

  localparam int BD = 4;
  localparam int FD = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  daddr;
  logic [15:0] ddata_write;
  logic        dwrite;
  logic [15:0] ddata_read;
  logic        uart_tx;
  logic [7:0]  led;

  always #5 clk = ~clk;

  forth_dbus #(.width(16), .daddr_width(8), .baud_div(BD), .fifo_depth(FD)) dut (
    .clk(clk), .reset(reset), .daddr(daddr), .ddata_write(ddata_write),
    .dwrite(dwrite), .ddata_read(ddata_read), .uart_tx(uart_tx), .led(led)
  );

  int total = 0;
  int bad   = 0;

  // Behavioural model: queue of bytes plus a frame timer measured in clocks
  logic [15:0] m_ram [0:239];
  bit          m_val [0:239];
  logic [7:0]  m_led;
  logic [15:0] m_cnt;
  bit          m_ovf;
  logic [7:0]  m_q [$];
  bit          m_act;
  int          m_pos;
  logic [7:0]  m_byte;
  logic [15:0] m_rd;
  bit          m_rd_ok;
  bit          m_live = 1'b0;

  function automatic logic m_bit();
    int k;
    if (!m_act) return 1'b1;
    k = m_pos / BD;
    if (k == 0) return 1'b0;
    if (k <= 8) return m_byte[k-1];
    return 1'b1;
  endfunction

  task automatic model_edge(input logic [7:0] a, input logic [15:0] wd,
                            input logic we, input logic rs);
    bit full, busy;
    if (rs) begin
      m_rd = 16'h0; m_rd_ok = 1'b1; m_led = 8'h0; m_cnt = 16'h0; m_ovf = 1'b0;
      m_q.delete(); m_act = 1'b0; m_pos = 0; m_live = 1'b1;
      return;
    end
    full = (m_q.size() == FD);
    busy = (m_q.size() != 0) || m_act;
    m_rd_ok = 1'b1;
    if (a < 8'hF0) begin
      m_rd = m_ram[a]; m_rd_ok = m_val[a];
    end else begin
      case (a)
        8'hF1:   m_rd = {13'd0, m_ovf, full, busy};
        8'hF2:   m_rd = {8'd0, m_led};
        8'hF3:   m_rd = m_cnt;
        default: m_rd = 16'h0;
      endcase
    end
    if (m_act) begin
      m_pos++;
      if (m_pos == 10 * BD) m_act = 1'b0;
    end
    if (!m_act && m_q.size() != 0) begin
      m_byte = m_q.pop_front(); m_act = 1'b1; m_pos = 0;
    end
    if (we && a == 8'hF0) begin
      if (full) m_ovf = 1'b1;
      else m_q.push_back(wd[7:0]);
    end
    if (we && a == 8'hF1) m_ovf = 1'b0;
    if (we && a == 8'hF2) m_led = wd[7:0];
    m_cnt = (we && a == 8'hF3) ? wd : m_cnt + 16'd1;
    if (we && a < 8'hF0) begin
      m_ram[a] = wd; m_val[a] = 1'b1;
    end
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%h want=%h", nm, $time, act, exp);
    end
  endtask

  task automatic tick(input logic [7:0] a, input logic [15:0] wd,
                      input logic we, input logic rs);
    daddr = a; ddata_write = wd; dwrite = we; reset = rs;
    @(posedge clk);
    model_edge(a, wd, we, rs);
    #1;
    if (m_live) begin
      check("model_tx", 32'(uart_tx), 32'(m_bit()));
      check("model_led", 32'(led), 32'(m_led));
      if (m_rd_ok) check("model_rd", 32'(ddata_read), 32'(m_rd));
    end
  endtask

  typedef struct {
    logic [7:0]  a;
    logic [15:0] wd;
    logic        we;
    logic        chk;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl [19];
  logic stream [0:199];
  logic [7:0] bytes5 [0:4];
  logic [7:0] a5;

  initial begin
    int sel;
    logic [7:0] ra;
    logic rwe, rrs;
    logic exp_bit;
    int j;

    tbl[0]  = '{8'h10, 16'h1234, 1'b1, 1'b0, 16'h0000};
    tbl[1]  = '{8'h10, 16'h0000, 1'b0, 1'b1, 16'h1234};
    tbl[2]  = '{8'h11, 16'hBEEF, 1'b1, 1'b0, 16'h0000};
    tbl[3]  = '{8'h11, 16'h0001, 1'b1, 1'b1, 16'hBEEF};
    tbl[4]  = '{8'h11, 16'h0000, 1'b0, 1'b1, 16'h0001};
    tbl[5]  = '{8'hF2, 16'h12A5, 1'b1, 1'b1, 16'h0000};
    tbl[6]  = '{8'hF2, 16'h0000, 1'b0, 1'b1, 16'h00A5};
    tbl[7]  = '{8'hF3, 16'hFFFF, 1'b1, 1'b0, 16'h0000};
    tbl[8]  = '{8'hF3, 16'h0000, 1'b0, 1'b1, 16'hFFFF};
    tbl[9]  = '{8'hF3, 16'h0000, 1'b0, 1'b1, 16'h0000};
    tbl[10] = '{8'hF0, 16'h0000, 1'b0, 1'b1, 16'h0000};
    tbl[11] = '{8'hF5, 16'h5555, 1'b1, 1'b1, 16'h0000};
    tbl[12] = '{8'hF5, 16'h0000, 1'b0, 1'b1, 16'h0000};
    tbl[13] = '{8'hF1, 16'h0000, 1'b0, 1'b1, 16'h0000};
    tbl[14] = '{8'hEF, 16'h0F0F, 1'b1, 1'b0, 16'h0000};
    tbl[15] = '{8'hEF, 16'h0000, 1'b0, 1'b1, 16'h0F0F};
    tbl[16] = '{8'hFF, 16'h0000, 1'b0, 1'b1, 16'h0000};
    tbl[17] = '{8'hF2, 16'h0000, 1'b1, 1'b1, 16'h00A5};
    tbl[18] = '{8'hF2, 16'h0000, 1'b0, 1'b1, 16'h0000};

    // reset state
    tick(8'h00, 16'h0, 1'b0, 1'b1);
    tick(8'h00, 16'h0, 1'b0, 1'b1);
    check("rst_rd", 32'(ddata_read), 32'h0);
    check("rst_tx", 32'(uart_tx), 32'h1);
    check("rst_led", 32'(led), 32'h0);
    $display("reset applied: rd=%h tx=%b led=%h", ddata_read, uart_tx, led);

    for (int i = 0; i < 19; i++) begin
      tick(tbl[i].a, tbl[i].wd, tbl[i].we, 1'b0);
      if (tbl[i].chk) check($sformatf("vec%0d", i), 32'(ddata_read), 32'(tbl[i].exp));
      $display("vec %0d addr=%h we=%0d wd=%h rd=%h", i, tbl[i].a, tbl[i].we, tbl[i].wd, ddata_read);
    end

    // single frame 0xA5: start, 1,0,1,0,0,1,0,1, stop
    a5 = 8'hA5;
    tick(8'hF0, 16'h00A5, 1'b1, 1'b0);
    check("a5_pre_tx", 32'(uart_tx), 32'h1);
    tick(8'h00, 16'h0, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      j = i / BD;
      exp_bit = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : a5[j-1];
      check($sformatf("a5_bit%0d", i), 32'(uart_tx), 32'(exp_bit));
      tick(8'h00, 16'h0, 1'b0, 1'b0);
    end
    tick(8'hF1, 16'h0, 1'b0, 1'b0);
    check("a5_status", 32'(ddata_read), 32'h0);
    $display("frame A5 sent, status=%h", ddata_read);

    // five back-to-back frames
    bytes5[0] = 8'h3C; bytes5[1] = 8'h81; bytes5[2] = 8'hFF;
    bytes5[3] = 8'h00; bytes5[4] = 8'h5A;
    for (int f = 0; f < 5; f++)
      for (int k = 0; k < 10; k++)
        for (int b = 0; b < BD; b++)
          stream[f*40 + k*BD + b] = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : bytes5[f][k-1];
    for (int t = 0; t < 202; t++) begin
      if (t < 5) tick(8'hF0, {8'h00, bytes5[t]}, 1'b1, 1'b0);
      else tick(8'h00, 16'h0, 1'b0, 1'b0);
      j = t - 1;
      exp_bit = (j >= 0 && j < 200) ? stream[j] : 1'b1;
      check($sformatf("b2b_t%0d", t), 32'(uart_tx), 32'(exp_bit));
    end
    tick(8'hF1, 16'h0, 1'b0, 1'b0);
    check("b2b_status", 32'(ddata_read), 32'h0);
    $display("five frames sent, status=%h", ddata_read);

    // overflow: fifo_depth+2 pushes while busy
    for (int i = 0; i < FD + 2; i++) tick(8'hF0, 16'(8'h11 + i), 1'b1, 1'b0);
    tick(8'hF1, 16'h0, 1'b0, 1'b0);
    check("ovf_status", 32'(ddata_read), 32'h7);
    tick(8'hF1, 16'h0, 1'b1, 1'b0);
    tick(8'hF1, 16'h0, 1'b0, 1'b0);
    check("ovf_clear", 32'(ddata_read), 32'h3);
    for (int i = 0; i < 230; i++) tick(8'h00, 16'h0, 1'b0, 1'b0);
    tick(8'hF1, 16'h0, 1'b0, 1'b0);
    check("ovf_drained", 32'(ddata_read), 32'h0);
    $display("overflow sequence done, status=%h", ddata_read);

    // reset in the middle of a DATA bit, with a write attempted during reset
    tick(8'hF2, 16'h005A, 1'b1, 1'b0);
    tick(8'hF0, 16'h0033, 1'b1, 1'b0);
    tick(8'hF0, 16'h0044, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) tick(8'hF2, 16'h0, 1'b0, 1'b0);
    check("mid_led", 32'(led), 32'h5A);
    check("mid_rd", 32'(ddata_read), 32'h5A);
    tick(8'hF2, 16'h00FF, 1'b1, 1'b1);
    check("abort_tx", 32'(uart_tx), 32'h1);
    check("abort_led", 32'(led), 32'h0);
    check("abort_rd", 32'(ddata_read), 32'h0);
    for (int i = 0; i < 60; i++) begin
      tick(8'h00, 16'h0, 1'b0, 1'b0);
      check($sformatf("abort_idle%0d", i), 32'(uart_tx), 32'h1);
    end
    tick(8'hF1, 16'h0, 1'b0, 1'b0);
    check("abort_status", 32'(ddata_read), 32'h0);
    $display("reset abort done, tx=%b led=%h", uart_tx, led);

    // random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      sel = $urandom_range(0, 9);
      rwe = 1'(($urandom_range(0, 1)));
      if (sel <= 3) begin
        ra = 8'($urandom_range(0, 15));
        if (ra >= 8'd8) ra = 8'hE0 + ra;
      end else if (sel <= 5) begin
        ra = 8'hF0;
        rwe = ($urandom_range(0, 3) == 0);
      end else if (sel == 6) ra = 8'hF1;
      else if (sel == 7) ra = 8'hF2;
      else if (sel == 8) ra = 8'hF3;
      else ra = 8'($urandom_range(8'hF4, 8'hFF));
      rrs = ($urandom_range(0, 599) == 0);
      tick(ra, 16'($urandom), rwe, rrs);
    end
    $display("random traffic done");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
